bus_unit_mpio: RTL and testbench

Parametrised N-master bus unit for the sigma SoC. It splits each master's request stream by address bit 31: low half goes to external RAM ports, high half goes to an internal IO register bank (GPIO with byte-enable and set/clear, a free-running timer with compare interrupt). It tracks outstanding RAM reads per master, so IO and RAM responses never collide on one master's response channel.

---
 rtl/bus_unit_pkg.sv | 27 ++
 rtl/bus_unit_port.sv | 65 ++++++
 rtl/bus_unit_mpio.sv | 151 +++++++++++++++
 tb/tb_bus_unit_mpio.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_unit_pkg.sv
// Shared constants and helpers for the bus unit: IO register offsets,
// the IO-select address bit and the byte-enable merge used by GPIO_OUT.
package bus_unit_pkg;

  localparam int IO_SEL_BIT = 31;

  localparam logic [7:0] IO_GPIO_OUT  = 8'h00;
  localparam logic [7:0] IO_GPIO_IN   = 8'h04;
  localparam logic [7:0] IO_GPIO_SET  = 8'h08;
  localparam logic [7:0] IO_GPIO_CLR  = 8'h0C;
  localparam logic [7:0] IO_TIMER     = 8'h10;
  localparam logic [7:0] IO_TIMER_CMP = 8'h14;
  localparam logic [7:0] IO_IRQ_STAT  = 8'h18;
  // Unmapped offset used to express "no write from this master"
  localparam logic [7:0] IO_NO_WRITE  = 8'hFF;

  localparam logic [31:0] IO_DUMMY_RDATA = 32'h55aa55aa;

  function automatic logic [31:0] be_merge(input logic [31:0] i_old,
                                           input logic [31:0] i_new,
                                           input logic [3:0]  i_be);
    logic [31:0] v_mask;
    v_mask = {{8{i_be[3]}}, {8{i_be[2]}}, {8{i_be[1]}}, {8{i_be[0]}}};
    return (i_old & ~v_mask) | (i_new & v_mask);
  endfunction

endpackage

// File: rtl/bus_unit_port.sv
// Per-master slice: address decode, outstanding RAM-read counter, IO stall,
// IO response flag/buffer and the response mux onto the master's channel.
module bus_unit_port #(
  parameter int OUTST_W = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic        i_io_sel,
  input  logic        i_ram_ack,
  input  logic        i_ram_resp,
  input  logic [31:0] i_ram_rdata,
  input  logic [31:0] i_io_rdata,
  output logic        o_ram_req,
  output logic        o_io_acc,
  output logic        o_bus_ack,
  output logic        o_bus_resp,
  output logic [31:0] o_bus_rdata
);

  localparam logic [OUTST_W-1:0] CNT_MAX  = {OUTST_W{1'b1}};
  localparam logic [OUTST_W-1:0] CNT_ZERO = {OUTST_W{1'b0}};
  localparam logic [OUTST_W-1:0] CNT_ONE  = OUTST_W'(1'b1);

  logic [OUTST_W-1:0] r_cnt;
  logic               r_io_resp;
  logic [31:0]        r_io_rdata;
  logic               w_ram_read_acc;

  // Decode, stall and response mux; IO waits until no RAM read is in flight
  always_comb begin
    o_ram_req      = i_req & ~i_io_sel & (r_cnt != CNT_MAX);
    o_io_acc       = i_req & i_io_sel & (r_cnt == CNT_ZERO);
    o_bus_ack      = o_ram_req ? i_ram_ack : o_io_acc;
    w_ram_read_acc = o_ram_req & i_ram_ack & ~i_we;
    o_bus_resp     = r_io_resp | i_ram_resp;
    o_bus_rdata    = r_io_resp ? r_io_rdata : i_ram_rdata;
  end

  // Outstanding RAM-read counter
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= CNT_ZERO;
    end else if (w_ram_read_acc && !i_ram_resp) begin
      r_cnt <= r_cnt + CNT_ONE;
    end else if (!w_ram_read_acc && i_ram_resp) begin
      r_cnt <= r_cnt - CNT_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // One-cycle IO read response, data captured from the pre-write register view
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_io_resp  <= 1'b0;
      r_io_rdata <= 32'h0000_0000;
    end else begin
      r_io_resp  <= o_io_acc & ~i_we;
      r_io_rdata <= (o_io_acc && !i_we) ? i_io_rdata : r_io_rdata;
    end
  end

endmodule

// File: rtl/bus_unit_mpio.sv
// N-master bus unit: bit 31 splits traffic between the RAM ports and a shared
// IO bank (GPIO out/in/set/clear, free-running timer with compare interrupt).
module bus_unit_mpio
  import bus_unit_pkg::*;
#(
  parameter int N_BUS   = 2,
  parameter int GPIO_W  = 32,
  parameter int OUTST_W = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [N_BUS-1:0]      bus_req_i,
  input  logic [N_BUS-1:0]      bus_we_i,
  input  logic [32*N_BUS-1:0]   bus_addr_bi,
  input  logic [4*N_BUS-1:0]    bus_be_bi,
  input  logic [32*N_BUS-1:0]   bus_wdata_bi,
  output logic [N_BUS-1:0]      bus_ack_o,
  output logic [N_BUS-1:0]      bus_resp_o,
  output logic [32*N_BUS-1:0]   bus_rdata_bo,
  output logic [N_BUS-1:0]      ram_req_o,
  output logic [N_BUS-1:0]      ram_we_o,
  output logic [30*N_BUS-1:0]   ram_addr_bo,
  output logic [4*N_BUS-1:0]    ram_be_bo,
  output logic [32*N_BUS-1:0]   ram_wdata_bo,
  input  logic [N_BUS-1:0]      ram_ack_i,
  input  logic [N_BUS-1:0]      ram_resp_i,
  input  logic [32*N_BUS-1:0]   ram_rdata_bi,
  input  logic [GPIO_W-1:0]     gpio_bi,
  output logic [GPIO_W-1:0]     gpio_bo,
  output logic                  irq_o
);

  logic [GPIO_W-1:0] r_gpio_out;
  logic [GPIO_W-1:0] r_sync1;
  logic [GPIO_W-1:0] r_sync2;
  logic [31:0]       r_timer;
  logic [31:0]       r_cmp;
  logic              r_irq;

  logic [N_BUS-1:0]  w_io_acc;
  logic [31:0]       w_io_rdata [N_BUS];
  logic [31:0]       w_gpio_out_ext;
  logic [31:0]       w_gpio_in_ext;
  logic [31:0]       w_gpio_nxt;
  logic [31:0]       w_timer_nxt;
  logic [31:0]       w_cmp_nxt;
  logic              w_irq_nxt;
  logic [7:0]        w_wr_off;
  logic [31:0]       w_wdata;
  logic [3:0]        w_be;

  assign w_gpio_out_ext = 32'(r_gpio_out);
  assign w_gpio_in_ext  = 32'(r_sync2);

  for (genvar g = 0; g < N_BUS; g++) begin : g_port
    bus_unit_port #(.OUTST_W(OUTST_W)) u_port (
      .i_clk       (clk_i),
      .i_rst       (rst_i),
      .i_req       (bus_req_i[g]),
      .i_we        (bus_we_i[g]),
      .i_io_sel    (bus_addr_bi[g*32+IO_SEL_BIT]),
      .i_ram_ack   (ram_ack_i[g]),
      .i_ram_resp  (ram_resp_i[g]),
      .i_ram_rdata (ram_rdata_bi[g*32 +: 32]),
      .i_io_rdata  (w_io_rdata[g]),
      .o_ram_req   (ram_req_o[g]),
      .o_io_acc    (w_io_acc[g]),
      .o_bus_ack   (bus_ack_o[g]),
      .o_bus_resp  (bus_resp_o[g]),
      .o_bus_rdata (bus_rdata_bo[g*32 +: 32])
    );
    assign ram_addr_bo[g*30 +: 30] = bus_addr_bi[g*32+2 +: 30];
  end

  assign ram_we_o     = bus_we_i;
  assign ram_be_bo    = bus_be_bi;
  assign ram_wdata_bo = bus_wdata_bi;
  assign gpio_bo      = r_gpio_out;
  assign irq_o        = r_irq;

  // IO read mux per master, always from the start-of-cycle register values
  always_comb begin
    for (int i = 0; i < N_BUS; i++) begin
      w_io_rdata[i] = IO_DUMMY_RDATA;
      case (bus_addr_bi[i*32 +: 8])
        IO_GPIO_OUT:  w_io_rdata[i] = w_gpio_out_ext;
        IO_GPIO_IN:   w_io_rdata[i] = w_gpio_in_ext;
        IO_GPIO_SET:  w_io_rdata[i] = 32'h0000_0000;
        IO_GPIO_CLR:  w_io_rdata[i] = 32'h0000_0000;
        IO_TIMER:     w_io_rdata[i] = r_timer;
        IO_TIMER_CMP: w_io_rdata[i] = r_cmp;
        IO_IRQ_STAT:  w_io_rdata[i] = {31'h0000_0000, r_irq};
        default:      w_io_rdata[i] = IO_DUMMY_RDATA;
      endcase
    end
  end

  // Write merge: masters applied in index order, each on the running value
  always_comb begin
    w_gpio_nxt  = w_gpio_out_ext;
    w_timer_nxt = r_timer + 32'd1;
    w_cmp_nxt   = r_cmp;
    w_irq_nxt   = r_irq;
    w_wr_off    = IO_NO_WRITE;
    w_wdata     = 32'h0000_0000;
    w_be        = 4'h0;
    for (int i = 0; i < N_BUS; i++) begin
      w_wr_off = (w_io_acc[i] & bus_we_i[i]) ? bus_addr_bi[i*32 +: 8] : IO_NO_WRITE;
      w_wdata  = bus_wdata_bi[i*32 +: 32];
      w_be     = bus_be_bi[i*4 +: 4];
      case (w_wr_off)
        IO_GPIO_OUT:  w_gpio_nxt  = be_merge(w_gpio_nxt, w_wdata, w_be);
        IO_GPIO_SET:  w_gpio_nxt  = w_gpio_nxt | w_wdata;
        IO_GPIO_CLR:  w_gpio_nxt  = w_gpio_nxt & ~w_wdata;
        IO_TIMER:     w_timer_nxt = w_wdata;
        IO_TIMER_CMP: w_cmp_nxt   = w_wdata;
        IO_IRQ_STAT:  w_irq_nxt   = w_irq_nxt & ~w_wdata[0];
        default:      w_cmp_nxt   = w_cmp_nxt;
      endcase
    end
    // A compare match wins over a same-cycle clear
    w_irq_nxt = w_irq_nxt | (r_timer == r_cmp);
  end

  // IO register bank and timer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_gpio_out <= {GPIO_W{1'b0}};
      r_timer    <= 32'h0000_0000;
      r_cmp      <= 32'hFFFF_FFFF;
      r_irq      <= 1'b0;
    end else begin
      r_gpio_out <= w_gpio_nxt[GPIO_W-1:0];
      r_timer    <= w_timer_nxt;
      r_cmp      <= w_cmp_nxt;
      r_irq      <= w_irq_nxt;
    end
  end

  // Two-flop synchroniser for the asynchronous GPIO inputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync1 <= {GPIO_W{1'b0}};
      r_sync2 <= {GPIO_W{1'b0}};
    end else begin
      r_sync1 <= gpio_bi;
      r_sync2 <= r_sync1;
    end
  end

endmodule

// File: tb/tb_bus_unit_mpio.sv
// Self-checking bench for bus_unit_mpio: directed scenarios followed by random
// traffic, all checked cycle by cycle against a behavioural model of the unit.
module tb_bus_unit_mpio;

  localparam int N = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    bus_req, bus_we, bus_ack, bus_resp;
  logic [N-1:0]    ram_req, ram_we, ram_ack, ram_resp;
  logic [32*N-1:0] bus_addr, bus_wdata, bus_rdata, ram_wdata, ram_rdata;
  logic [4*N-1:0]  bus_be, ram_be;
  logic [30*N-1:0] ram_addr;
  logic [31:0]     gpio_in, gpio_bo;
  logic            irq;

  // Behavioural model state
  logic [31:0] m_gpio, m_timer, m_cmp, m_s1, m_s2;
  logic        m_irq;
  int          m_cnt   [N];
  logic        m_pend  [N];
  logic [31:0] m_pdata [N];
  int          ram_q   [N][$];
  logic [31:0] ram_d   [N][$];
  int          ram_delay;
  int          cyc;
  logic [N-1:0] obs_ack, obs_rreq;
  logic        obs_irq;
  int          tests, fails;
  int          att, found;
  logic [7:0]  offs [9] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h40};

  bus_unit_mpio #(.N_BUS(N), .GPIO_W(32), .OUTST_W(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .bus_req_i(bus_req), .bus_we_i(bus_we), .bus_addr_bi(bus_addr),
    .bus_be_bi(bus_be), .bus_wdata_bi(bus_wdata),
    .bus_ack_o(bus_ack), .bus_resp_o(bus_resp), .bus_rdata_bo(bus_rdata),
    .ram_req_o(ram_req), .ram_we_o(ram_we), .ram_addr_bo(ram_addr),
    .ram_be_bo(ram_be), .ram_wdata_bo(ram_wdata),
    .ram_ack_i(ram_ack), .ram_resp_i(ram_resp), .ram_rdata_bi(ram_rdata),
    .gpio_bi(gpio_in), .gpio_bo(gpio_bo), .irq_o(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_gpio = 32'h0; m_timer = 32'h0; m_cmp = 32'hFFFF_FFFF; m_irq = 1'b0;
    m_s1 = 32'h0; m_s2 = 32'h0;
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0; m_pend[i] = 1'b0; m_pdata[i] = 32'h0;
      ram_q[i].delete(); ram_d[i].delete();
    end
  endtask

  function automatic logic [31:0] io_read(input logic [7:0] off);
    case (off)
      8'h00:        return m_gpio;
      8'h04:        return m_s2;
      8'h08, 8'h0C: return 32'h0;
      8'h10:        return m_timer;
      8'h14:        return m_cmp;
      8'h18:        return {31'h0, m_irq};
      default:      return 32'h55aa55aa;
    endcase
  endfunction

  task automatic drive(input int m, input logic req, input logic we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wd);
    bus_req[m] = req; bus_we[m] = we;
    bus_addr[m*32 +: 32] = addr; bus_be[m*4 +: 4] = be; bus_wdata[m*32 +: 32] = wd;
  endtask

  task automatic idle();
    for (int m = 0; m < N; m++) drive(m, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  // One clock cycle: present RAM responses, check outputs mid-cycle, advance the model
  task automatic step();
    logic [N-1:0] e_ack, e_resp, e_rreq;
    logic         iacc [N];
    logic         racc [N];
    logic [31:0]  rd   [N];
    logic [31:0]  a, wd, n_gpio, n_timer, n_cmp;
    logic         n_irq;
    for (int i = 0; i < N; i++) begin
      if (!rst && ram_q[i].size() > 0 && ram_q[i][0] <= cyc) begin
        ram_resp[i] = 1'b1; ram_rdata[i*32 +: 32] = ram_d[i][0];
      end else begin
        ram_resp[i] = 1'b0; ram_rdata[i*32 +: 32] = $urandom;
      end
    end
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      a = bus_addr[i*32 +: 32];
      e_rreq[i] = bus_req[i] & ~a[31] & (m_cnt[i] != 3);
      iacc[i]   = bus_req[i] & a[31] & (m_cnt[i] == 0);
      e_ack[i]  = e_rreq[i] ? ram_ack[i] : iacc[i];
      racc[i]   = e_rreq[i] & ram_ack[i] & ~bus_we[i];
      e_resp[i] = m_pend[i] | ram_resp[i];
      rd[i]     = io_read(a[7:0]);
      if (e_resp[i])
        chk($sformatf("rdata%0d", i), bus_rdata[i*32 +: 32],
            m_pend[i] ? m_pdata[i] : ram_rdata[i*32 +: 32]);
    end
    chk("ack", bus_ack, e_ack);
    chk("resp", bus_resp, e_resp);
    chk("ram_req", ram_req, e_rreq);
    chk("gpio_bo", gpio_bo, m_gpio);
    chk("irq", irq, m_irq);
    chk("ram_addr", ram_addr, {bus_addr[63:34], bus_addr[31:2]});
    obs_ack = bus_ack; obs_rreq = ram_req; obs_irq = irq;
    n_gpio = m_gpio; n_timer = m_timer + 32'd1; n_cmp = m_cmp; n_irq = m_irq;
    for (int i = 0; i < N; i++) begin
      if (iacc[i] && bus_we[i]) begin
        wd = bus_wdata[i*32 +: 32];
        case (bus_addr[i*32 +: 8])
          8'h00: for (int b = 0; b < 4; b++) if (bus_be[i*4+b]) n_gpio[b*8 +: 8] = wd[b*8 +: 8];
          8'h08: n_gpio = n_gpio | wd;
          8'h0C: n_gpio = n_gpio & ~wd;
          8'h10: n_timer = wd;
          8'h14: n_cmp = wd;
          8'h18: if (wd[0]) n_irq = 1'b0;
          default: ;
        endcase
      end
    end
    if (m_timer == m_cmp) n_irq = 1'b1;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m_s2 = m_s1; m_s1 = gpio_in;
      m_gpio = n_gpio; m_timer = n_timer; m_cmp = n_cmp; m_irq = n_irq;
      for (int i = 0; i < N; i++) begin
        m_pend[i]  = iacc[i] & ~bus_we[i];
        m_pdata[i] = rd[i];
        if (ram_resp[i]) begin
          void'(ram_q[i].pop_front()); void'(ram_d[i].pop_front()); m_cnt[i]--;
        end
        if (racc[i]) begin
          ram_q[i].push_back(cyc + (ram_delay > 0 ? ram_delay : int'($urandom_range(1, 6))));
          ram_d[i].push_back($urandom);
          m_cnt[i]++;
        end
      end
    end
    cyc++;
    #1;
    ram_resp = '0;
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0; ram_delay = 0;
    rst = 1'b1; ram_ack = 2'b00; ram_resp = 2'b00; ram_rdata = '0; gpio_in = 32'h0;
    idle();
    model_reset();
    step(); step();
    chk("rst_gpio_bo", gpio_bo, 32'h0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_resp", bus_resp, 2'b00);
    rst = 1'b0;

    // Reset value of TIMER_CMP
    drive(0, 1'b1, 1'b0, 32'h8000_0014, 4'hF, 32'h0); step(); idle();
    chk("cmp_rd_resp", bus_resp[0], 1'b1);
    chk("cmp_rd_data", bus_rdata[31:0], 32'hFFFF_FFFF);
    step();

    // Byte-enabled GPIO_OUT write, read back from the other master
    drive(0, 1'b1, 1'b1, 32'h8000_0000, 4'b0011, 32'hDEAD_BEEF); step(); idle();
    chk("gpio_be_write", gpio_bo, 32'h0000_BEEF);
    drive(1, 1'b1, 1'b0, 32'h8000_0000, 4'hF, 32'h0); step(); idle();
    chk("gpio_rd_m1", bus_rdata[63:32], 32'h0000_BEEF);
    step();

    // Simultaneous SET/CLR resolved in master order
    drive(0, 1'b1, 1'b1, 32'h8000_0008, 4'hF, 32'h0000_00FF);
    drive(1, 1'b1, 1'b1, 32'h8000_000C, 4'hF, 32'h0000_000F); step(); idle();
    chk("set_then_clr", gpio_bo[7:0], 8'hF0);
    drive(0, 1'b1, 1'b1, 32'h8000_000C, 4'hF, 32'h0000_000F);
    drive(1, 1'b1, 1'b1, 32'h8000_0008, 4'hF, 32'h0000_00FF); step(); idle();
    chk("clr_then_set", gpio_bo[7:0], 8'hFF);

    // IO read stalls behind an outstanding RAM read (RAM answers 5 cycles later)
    ram_ack = 2'b11; ram_delay = 5;
    drive(0, 1'b1, 1'b0, 32'h0000_1000, 4'hF, 32'h0); step();
    drive(0, 1'b1, 1'b0, 32'h8000_0000, 4'hF, 32'h0);
    att = 0; found = 0;
    for (int j = 0; j < 20 && found == 0; j++) begin
      step(); att++;
      if (obs_ack[0]) found = 1;
    end
    idle();
    chk("stall_attempts", att, 6);
    chk("io_resp_after_stall", bus_resp[0], 1'b1);
    step();

    // Fourth outstanding RAM read is held back
    ram_delay = 30;
    for (int j = 0; j < 4; j++) begin
      drive(0, 1'b1, 1'b0, 32'h0000_2000 + 32'(j * 4), 4'hF, 32'h0); step();
      chk($sformatf("outst_req%0d", j), obs_rreq[0], (j == 3) ? 1'b0 : 1'b1);
    end
    idle();
    for (int j = 0; j < 40; j++) step();
    ram_delay = 0;

    // Timer compare interrupt: TIMER=10, CMP=14 written together
    drive(0, 1'b1, 1'b1, 32'h8000_0010, 4'hF, 32'd10);
    drive(1, 1'b1, 1'b1, 32'h8000_0014, 4'hF, 32'd14); step(); idle();
    att = 0; found = 0;
    for (int j = 1; j <= 20 && found == 0; j++) begin
      step();
      if (obs_irq) begin att = j; found = 1; end
    end
    chk("irq_latency", att, 6);
    drive(0, 1'b1, 1'b1, 32'h8000_0018, 4'hF, 32'h1); step(); idle();
    chk("irq_w1c", irq, 1'b0);

    // Clear in the match cycle loses to the set
    drive(0, 1'b1, 1'b1, 32'h8000_0010, 4'hF, 32'd100);
    drive(1, 1'b1, 1'b1, 32'h8000_0014, 4'hF, 32'd103); step(); idle();
    step(); step(); step();
    drive(0, 1'b1, 1'b1, 32'h8000_0018, 4'hF, 32'h1); step(); idle();
    chk("irq_set_beats_clr", irq, 1'b1);

    // Unmapped offset
    drive(0, 1'b1, 1'b0, 32'h8000_0040, 4'hF, 32'h0); step(); idle();
    chk("dummy_rdata", bus_rdata[31:0], 32'h55aa55aa);
    step();

    // Reset in the cycle after an IO read ack drops the response
    drive(0, 1'b1, 1'b0, 32'h8000_0004, 4'hF, 32'h0); step(); idle();
    rst = 1'b1; #1;
    model_reset();
    chk("rst_mid_resp", bus_resp, 2'b00);
    chk("rst_mid_gpio", gpio_bo, 32'h0);
    chk("rst_mid_irq", irq, 1'b0);
    step();
    rst = 1'b0;
    step();

    // Random traffic against the model
    for (int c = 0; c < 300; c++) begin
      gpio_in = $urandom;
      for (int m = 0; m < N; m++) begin
        ram_ack[m] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 1) == 1)
          drive(m, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                {1'b1, 23'($urandom), offs[$urandom_range(0, 8)]}, 4'($urandom), $urandom);
        else
          drive(m, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                {1'b0, 31'($urandom)}, 4'($urandom), $urandom);
      end
      step();
    end
    idle();
    for (int j = 0; j < 12; j++) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
